// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode encodings shared by the logic unit pipeline
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NOT     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XOR     = 3'd5,
    OP_XNOR    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_t;

endpackage

// File: rtl/logic_op_core.sv
// rtl/logic_op_core.sv - combinational gate operation select
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined logic unit with accumulator and reduction flags
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = logic_unit_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic             zero,
  output logic             err
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic             s1_err;
  logic             s2_valid;
  logic [WIDTH-1:0] acc;

  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] core_result;
  logic             core_err;
  op_t              op_sel;

  // Ready depends only on registered valids and out_ready, never on in_valid.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && s1_adv;
  assign out_valid = s2_valid;

  assign acc_eff = acc_clr ? '0 : acc;
  assign b_eff   = acc_en ? acc_eff : b;
  assign op_sel  = op_t'(op);

  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a),
    .b      (b_eff),
    .op     (op_sel),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_err    <= 1'b0;
      s2_valid  <= 1'b0;
      y         <= '0;
      red_and   <= 1'b0;
      red_or    <= 1'b0;
      red_xor   <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_result <= core_result;
          s1_err    <= core_err;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          y       <= s1_result;
          red_and <= &s1_result;
          red_or  <= |s1_result;
          red_xor <= ^s1_result;
          zero    <= (s1_result == '0);
          err     <= s1_err;
        end
      end
      // Accumulator moves at accept time, so the next beat already sees it.
      if (accept && acc_en && !core_err) begin
        acc <= core_result;
      end else if (acc_clr) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_en;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       red_and;
  logic       red_or;
  logic       red_xor;
  logic       zero;
  logic       err;

  logic_unit_pipe #(.WIDTH(8), .OP_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic       err;
    int         edge_n;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int         got_edge[$];
  logic [7:0] exp_list[$];
  logic [7:0] m_acc;
  int         edge_cnt;
  bit         chk_lat;
  bit         prev_stall;
  logic [7:0] prev_y;
  int         vectors;
  int         miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [8:0] ref_op(input int o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      0: return {1'b0, x & z};
      1: return {1'b0, x | z};
      2: return {1'b0, ~x};
      3: return {1'b0, ~(x & z)};
      4: return {1'b0, ~(x | z)};
      5: return {1'b0, x ^ z};
      6: return {1'b0, ~(x ^ z)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic drive(input logic v, input int o, input logic [7:0] x, input logic [7:0] z,
                       input logic en, input logic clr);
    in_valid = v;
    op       = 3'(o);
    a        = x;
    b        = z;
    acc_en   = en;
    acc_clr  = clr;
  endtask

  // One clock: sample handshakes before the edge, update the model, then step past the edge.
  task automatic cycle();
    bit         fire_in;
    bit         fire_out;
    logic [7:0] beff;
    logic [8:0] r;
    exp_t       e;
    #2;
    if (prev_stall) begin
      check("hold_y", y, prev_y);
      check("hold_valid", out_valid, 1);
    end
    fire_out = rst_n && out_valid && out_ready;
    if (fire_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("y", y, e.y);
        check("err", err, e.err);
        check("zero", zero, e.y == 8'h00);
        check("red_and", red_and, e.y == 8'hFF);
        check("red_or", red_or, e.y != 8'h00);
        check("red_xor", red_xor, ones(e.y) % 2);
        if (chk_lat) check("latency", edge_cnt - e.edge_n, 2);
        got_q.push_back(y);
        got_edge.push_back(edge_cnt);
      end
    end
    fire_in    = rst_n && in_valid && in_ready;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_y     = y;
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 8'h00;
    end else if (fire_in) begin
      beff = acc_en ? (acc_clr ? 8'h00 : m_acc) : b;
      r    = ref_op(int'(op), a, beff);
      exp_q.push_back('{y: r[7:0], err: r[8], edge_n: edge_cnt});
      if (acc_en && !r[8]) m_acc = r[7:0];
      else if (acc_clr) m_acc = 8'h00;
    end else if (acc_clr) begin
      m_acc = 8'h00;
    end
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got_q.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_list[i]);
    got_q.delete();
    got_edge.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_cnt    = 0;
    chk_lat     = 0;
    prev_stall  = 0;
    prev_y      = 8'h00;
    m_acc       = 8'h00;
    out_ready   = 1'b1;
    rst_n       = 1'b0;
    drive(1'b1, 1, 8'h5A, 8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_err", err, 0);
    end
    rst_n = 1'b1;
    drive(1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    check("rst_in_ready", in_ready, 1);

    // All legal ops streamed back-to-back
    chk_lat = 1;
    for (int o = 0; o < 7; o++) begin
      drive(1'b1, o, 8'hF0, 8'h3C, 1'b0, 1'b0);
      check("stream_in_ready", in_ready, 1);
      cycle();
    end
    drain();
    chk_lat = 0;
    exp_list = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33};
    check_got("stream");

    // Backpressure: two beats fill the pipe, third waits
    out_ready = 1'b0;
    drive(1'b1, 0, 8'hFF, 8'h0F, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 0, 8'hFF, 8'hF0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 0, 8'hAA, 8'hFF, 1'b0, 1'b0);
    check("bp_in_ready", in_ready, 0);
    cycle();
    cycle();
    check("bp_in_ready_held", in_ready, 0);
    out_ready = 1'b1;
    cycle();
    drain();
    check("bp_spacing0", got_edge[1] - got_edge[0], 1);
    check("bp_spacing1", got_edge[2] - got_edge[1], 1);
    exp_list = '{8'h0F, 8'hF0, 8'hAA};
    check_got("bp");

    // Accumulate chain
    drive(1'b1, 1, 8'h01, 8'hEE, 1'b1, 1'b1); cycle();
    drive(1'b1, 1, 8'h02, 8'hEE, 1'b1, 1'b0); cycle();
    drive(1'b1, 1, 8'h04, 8'hEE, 1'b1, 1'b0); cycle();
    drive(1'b1, 5, 8'h07, 8'hEE, 1'b1, 1'b0); cycle();
    drive(1'b1, 1, 8'h80, 8'hEE, 1'b1, 1'b1); cycle();
    drain();
    exp_list = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h80};
    check_got("acc");

    // Illegal op leaves the accumulator alone
    drive(1'b1, 7, 8'hFF, 8'hFF, 1'b1, 1'b0); cycle();
    drive(1'b1, 1, 8'h00, 8'h00, 1'b1, 1'b0); cycle();
    drain();
    exp_list = '{8'h00, 8'h80};
    check_got("illegal");

    // Reset with beats in flight and acc=5A
    drive(1'b1, 1, 8'h5A, 8'h00, 1'b1, 1'b1); cycle();
    drain();
    out_ready = 1'b0;
    drive(1'b1, 5, 8'h11, 8'h22, 1'b0, 1'b0); cycle();
    drive(1'b1, 5, 8'h33, 8'h44, 1'b0, 1'b0); cycle();
    drive(1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b1, 1, 8'h01, 8'h00, 1'b1, 1'b0); cycle();
    drain();
    exp_list = '{8'h5A, 8'h01};
    check_got("midrst");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    out_ready = 1'b1;
    drain();
    got_q.delete();
    got_edge.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit. It is the registered, multi-bit successor to the single-bit gate primitives.
- Applies one of seven selectable gate operations to WIDTH-bit operands.
- Optional accumulate mode folds each result back in as operand b.
- Registered reduction flags on every result.
- valid/ready handshake on both sides; sits between a producer stage and any consumer.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- OP_W, 3, opcode width (fixed by package encoding)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored when acc_en=1)
- op  in  OP_W  operation select
- acc_en  in  1  use accumulator as B; write result to accumulator
- acc_clr  in  1  clear accumulator
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- red_and  out  1  &y
- red_or  out  1  |y
- red_xor  out  1  ^y (parity)
- zero  out  1  y==0
- err  out  1  illegal opcode on this beat

Behaviour:
- Reset is synchronous, active-low: single clock, all state cleared on the clk edge with rst_n=0.
- Values held while rst_n=0:
  - s1_valid=0, s2_valid=0, acc=0
  - y=0, red_*=0, zero=0, err=0, out_valid=0
  - in_ready=1 from the first cycle after reset release.
- Opcodes:
  - 0 AND, 1 OR, 2 NOT (~a, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR
  - 7 illegal: result 0, err=1, accumulator NOT updated.
- Accept: in_valid && in_ready on a clk edge.
- Pipeline: two stages, latency exactly 2 cycles from accept to out_valid, throughput 1 beat/cycle when out_ready=1.
  - S1 registers {result, err}.
  - S2 registers {y, red_*, zero, err}; reductions are computed from the S1 result.
- Handshake:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - Combinational ready path only, no valid-to-ready loop.
  - Outputs are stable while out_valid && !out_ready.
  - Order is preserved; no beat is dropped or duplicated.
- Accumulator (WIDTH bits):
  - The effective B on an accepted beat is acc_en ? acc_eff : b.
  - acc_eff = acc_clr ? 0 : acc.
  - On an accepted beat with acc_en=1 and a legal op: acc <= result.
  - acc_clr without an accepted acc_en beat: acc <= 0.
  - acc_clr and an accepted acc_en beat in the same cycle: the clear applies first (B=0), then acc <= result.
  - acc_clr acts regardless of in_valid/in_ready.
  - acc_en is ignored when the beat is not accepted.
  - Back-to-back acc beats use the freshly updated accumulator; there is no hazard because acc updates at accept.
- Reset mid-operation: all in-flight beats are discarded, the accumulator is cleared, and out_valid=0 after the reset edge.

Decomposition:
- Package logic_unit_pkg:
  - OP_W
  - op encodings OP_AND..OP_XNOR, OP_ILLEGAL=3'd7
  - typedef op_t
- Sub-module logic_op_core: purely combinational (a, b, op) -> (result, err), instantiated once at S1 input.
- Pipeline, handshake, accumulator and reductions live in logic_unit_pipe.

Test Plan:
- Reset: hold rst_n=0 3 cycles with in_valid=1 -> out_valid=0, y=00, err=0 throughout; in_ready=1 first cycle after release.
- All ops streamed back-to-back, out_ready=1, a=F0, b=3C, op=0..6:
  - y=30,FC,0F,CF,03,CC,33, each 2 cycles after accept; in_ready stays 1.
  - red_xor: 0,0,0,0,0,0,0 (each result has an even number of ones).
  - red_or=1 for all beats.
- Backpressure, out_ready=0:
  - Offer beats AND a=FF b=0F, a=FF b=F0, a=AA b=FF.
  - First two accepted, then in_ready=0; the third is held with no loss.
  - Raise out_ready -> y=0F,F0,AA in order, one per cycle.
- Accumulate:
  - acc_clr=1 with acc_en=1, OR a=01 -> y=01.
  - Then OR a=02 -> 03; OR a=04 -> 07.
  - Then XOR a=07 -> y=00, zero=1, red_or=0.
  - Then clr+OR a=80 same cycle -> y=80.
- Illegal op: op=7, a=FF, b=FF, acc_en=1 -> y=00, err=1, zero=1. Next acc OR a=00 returns the prior accumulator value (unchanged).
- Reset mid-flight: two beats in S1/S2 with out_ready=0 and acc=5A; rst_n=0 one cycle.
  - out_valid=0 next cycle, no stale beat emitted.
  - Following acc OR a=01 -> y=01.
